rib_arbiter: RTL

Three-master, one-slave bus arbiter that sits directly downstream of the CPU core's data (ex) and fetch (pc) ports and the JTAG debug master. It serialises their requests onto a single registered request/acknowledge slave port toward the address decoder and memories. It also produces the core's bus-stall hold flag. Arbitration is fixed-priority and one transaction is outstanding at a time.

---
 rtl/rib_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rib_arbiter.sv
// rib_arbiter: three-master, one-slave fixed-priority bus arbiter.
//
// Masters:  m0 = core data port, m1 = core fetch port (read-only), m2 = JTAG debug.
// Priority: m0 > m2 > m1. One transaction outstanding at a time.
// FSM: IDLE (grant + latch) -> BUSY (wait s_ack_i) -> DONE (ack pulse, turnaround).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   m0_*                        data master: req/we/addr/wdata in, rdata/ack out
//   m1_*                        fetch master: req/addr in, rdata/ack out
//   m2_*                        debug master: req/we/addr/wdata in, rdata/ack out
//   s_*                         registered slave port: req/we/addr/wdata out, rdata/ack in
//   hold_flag_o                 combinational stall request to core control
//   grant_o                     owner: 0 none, 1 m0, 2 m1, 3 m2
//   err_o                       slave timeout pulse (coincides with the master ack)
//
// Optional feature macro: RIB_ARB_TIMEOUT_EN enables the BUSY timeout counter and err_o.
// Without it BUSY waits indefinitely and err_o is tied 0.
module rib_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_ack_o,
   input  logic              m1_req_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_ack_o,
   input  logic              m2_req_i,
   input  logic              m2_we_i,
   input  logic [ADDR_W-1:0] m2_addr_i,
   input  logic [DATA_W-1:0] m2_wdata_i,
   output logic [DATA_W-1:0] m2_rdata_o,
   output logic              m2_ack_o,
   output logic              s_req_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_wdata_o,
   input  logic [DATA_W-1:0] s_rdata_i,
   input  logic              s_ack_i,
   output logic              hold_flag_o,
   output logic [1:0]        grant_o,
   output logic              err_o
);

   if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range
      $error("rib_arbiter: TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   localparam logic [1:0] GntNone = 2'd0;
   localparam logic [1:0] GntM0   = 2'd1;
   localparam logic [1:0] GntM1   = 2'd2;
   localparam logic [1:0] GntM2   = 2'd3;

   state_e            state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              s_req_q, s_req_d;
   logic              s_we_q, s_we_d;
   logic [ADDR_W-1:0] s_addr_q, s_addr_d;
   logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic [DATA_W-1:0] m2_rdata_q, m2_rdata_d;
   logic              tmo;  // timeout fires this BUSY cycle (never when s_ack_i is high)

`ifdef RIB_ARB_TIMEOUT_EN
   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   always_comb begin
      tmo   = (state_q == StBusy) && !s_ack_i && (cnt_q + 8'd1 == TimeoutCnt);
      // Outside BUSY the counter sits at 0, so it is clear on every BUSY entry.
      cnt_d = (state_q == StBusy) ? cnt_q + 8'd1 : 8'd0;
      err_d = tmo;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign tmo   = 1'b0;
   assign err_o = 1'b0;
`endif

   always_comb begin
      logic [DATA_W-1:0] cap_val;
      state_d    = state_q;
      grant_d    = grant_q;
      s_req_d    = s_req_q;
      s_we_d     = s_we_q;
      s_addr_d   = s_addr_q;
      s_wdata_d  = s_wdata_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      m2_rdata_d = m2_rdata_q;
      cap_val    = s_ack_i ? s_rdata_i : '0;

      unique case (state_q)
         StIdle: begin
            if (m0_req_i) begin
               grant_d   = GntM0;
               s_we_d    = m0_we_i;
               s_addr_d  = m0_addr_i;
               s_wdata_d = m0_wdata_i;
            end else if (m2_req_i) begin
               grant_d   = GntM2;
               s_we_d    = m2_we_i;
               s_addr_d  = m2_addr_i;
               s_wdata_d = m2_wdata_i;
            end else if (m1_req_i) begin
               grant_d   = GntM1;
               s_we_d    = 1'b0;
               s_addr_d  = m1_addr_i;
            end
            if (m0_req_i || m1_req_i || m2_req_i) begin
               s_req_d = 1'b1;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (s_ack_i || tmo) begin
               // Writes leave the master's read data untouched.
               if (!s_we_q) begin
                  case (grant_q)
                     GntM0:   m0_rdata_d = cap_val;
                     GntM1:   m1_rdata_d = cap_val;
                     GntM2:   m2_rdata_d = cap_val;
                     default: ;
                  endcase
               end
               s_req_d = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            grant_d = GntNone;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         grant_q    <= GntNone;
         s_req_q    <= 1'b0;
         s_we_q     <= 1'b0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         m2_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         s_req_q    <= s_req_d;
         s_we_q     <= s_we_d;
         s_addr_q   <= s_addr_d;
         s_wdata_q  <= s_wdata_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
         m2_rdata_q <= m2_rdata_d;
      end
   end

   assign s_req_o    = s_req_q;
   assign s_we_o     = s_we_q;
   assign s_addr_o   = s_addr_q;
   assign s_wdata_o  = s_wdata_q;
   assign grant_o    = grant_q;
   assign m0_rdata_o = m0_rdata_q;
   assign m1_rdata_o = m1_rdata_q;
   assign m2_rdata_o = m2_rdata_q;

   // Acks are decoded from registered state, so they drop on reset asynchronously.
   assign m0_ack_o = (state_q == StDone) && (grant_q == GntM0);
   assign m1_ack_o = (state_q == StDone) && (grant_q == GntM1);
   assign m2_ack_o = (state_q == StDone) && (grant_q == GntM2);

   // m1 does not stall the core while its own fetch is in flight; debug ownership always does.
   assign hold_flag_o = (m0_req_i & ~m0_ack_o)
                      | (m1_req_i & ~m1_ack_o & (grant_q != GntM1))
                      | (grant_q == GntM2);

endmodule
